// File: rtl/mandel_iter_ctrl.sv
// Iteration sequencer for one Mandelbrot point: z(n+1) = z(n)^2 + c from z(0)=0, with escape
// test |z|^2 > 4.0 and an iteration limit; drives external squaring and adder units (IEEE754 doubles).
module mandel_iter_ctrl #(
  parameter int ITER_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [63:0]       c_re,
  input  logic [63:0]       c_im,
  input  logic [ITER_W-1:0] max_iter,
  output logic              busy,
  output logic              done,
  input  logic              ack,
  output logic              escaped,
  output logic [ITER_W-1:0] iter_count,
  output logic [63:0]       z_re,
  output logic [63:0]       z_im,
  output logic              sq_start,
  output logic              sq_ack,
  output logic [63:0]       sq_re,
  output logic [63:0]       sq_im,
  input  logic              sq_done,
  input  logic [63:0]       sq_re2,
  input  logic [63:0]       sq_im2,
  input  logic [63:0]       sq_reim,
  output logic              add_start,
  output logic              add_ack,
  output logic [63:0]       add_re_a,
  output logic [63:0]       add_re_b,
  output logic [63:0]       add_im_a,
  output logic [63:0]       add_im_b,
  input  logic              add_done,
  input  logic [63:0]       add_re_z,
  input  logic [63:0]       add_im_z
);

  // Unit handshake: xx_start = in_state && !xx_done; xx_ack = in_state && xx_done.
  // Results are captured on the done cycle and the state is left on that same edge.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SQ    = 3'd1,
    S_ADD1  = 3'd2,
    S_CHECK = 3'd3,
    S_ADD2  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [63:0] MAG_MASK  = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] FOUR_BITS = 64'h4010_0000_0000_0000;

  state_t              state_q, state_d;
  logic [63:0]         c_re_q, c_re_d, c_im_q, c_im_d;
  logic [ITER_W-1:0]   max_q, max_d;
  logic [ITER_W-1:0]   n_q, n_d, n_inc;
  logic                esc_q, esc_d;
  logic [63:0]         z_re_q, z_re_d, z_im_q, z_im_d;
  logic [63:0]         re2_q, re2_d, im2_q, im2_d, reim_q, reim_d;
  logic [63:0]         t_re_q, t_re_d, mag_q, mag_d;

  // Exact doubling of a double: exponent bump, denormal shift, or overflow to signed infinity.
  function automatic logic [63:0] dbl(input logic [63:0] x);
    logic [10:0] e;
    e = x[62:52];
    if (e == 11'd0)
      dbl = {x[63], x[61:0], 1'b0};
    else if (e == 11'h7FF)
      dbl = x;
    else if (e == 11'h7FE)
      dbl = {x[63], 11'h7FF, 52'd0};
    else
      dbl = {x[63], e + 11'd1, x[51:0]};
  endfunction

  assign n_inc = n_q + ITER_W'(1);

  always_comb begin
    state_d = state_q;
    c_re_d  = c_re_q;
    c_im_d  = c_im_q;
    max_d   = max_q;
    n_d     = n_q;
    esc_d   = esc_q;
    z_re_d  = z_re_q;
    z_im_d  = z_im_q;
    re2_d   = re2_q;
    im2_d   = im2_q;
    reim_d  = reim_q;
    t_re_d  = t_re_q;
    mag_d   = mag_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          c_re_d  = c_re;
          c_im_d  = c_im;
          max_d   = max_iter;
          n_d     = '0;
          esc_d   = 1'b0;
          z_re_d  = '0;
          z_im_d  = '0;
          state_d = (max_iter == '0) ? S_DONE : S_SQ;
        end
      end
      S_SQ: begin
        if (sq_done) begin
          re2_d   = sq_re2;
          im2_d   = sq_im2;
          reim_d  = sq_reim;
          state_d = S_ADD1;
        end
      end
      S_ADD1: begin
        if (add_done) begin
          t_re_d  = add_re_z;
          mag_d   = add_im_z;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        // Unsigned compare of the magnitude bits; any NaN pattern sorts above 4.0.
        if ((mag_q & MAG_MASK) > FOUR_BITS) begin
          esc_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_ADD2;
        end
      end
      S_ADD2: begin
        if (add_done) begin
          z_re_d  = add_re_z;
          z_im_d  = add_im_z;
          n_d     = n_inc;
          state_d = (n_inc == max_q) ? S_DONE : S_SQ;
        end
      end
      S_DONE: begin
        if (ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      c_re_q  <= '0;
      c_im_q  <= '0;
      max_q   <= '0;
      n_q     <= '0;
      esc_q   <= 1'b0;
      z_re_q  <= '0;
      z_im_q  <= '0;
      re2_q   <= '0;
      im2_q   <= '0;
      reim_q  <= '0;
      t_re_q  <= '0;
      mag_q   <= '0;
    end else begin
      state_q <= state_d;
      c_re_q  <= c_re_d;
      c_im_q  <= c_im_d;
      max_q   <= max_d;
      n_q     <= n_d;
      esc_q   <= esc_d;
      z_re_q  <= z_re_d;
      z_im_q  <= z_im_d;
      re2_q   <= re2_d;
      im2_q   <= im2_d;
      reim_q  <= reim_d;
      t_re_q  <= t_re_d;
      mag_q   <= mag_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign escaped    = esc_q;
  assign iter_count = n_q;
  assign z_re       = z_re_q;
  assign z_im       = z_im_q;

  assign sq_start  = (state_q == S_SQ) && !sq_done;
  assign sq_ack    = (state_q == S_SQ) && sq_done;
  assign sq_re     = z_re_q;
  assign sq_im     = z_im_q;

  assign add_start = ((state_q == S_ADD1) || (state_q == S_ADD2)) && !add_done;
  assign add_ack   = ((state_q == S_ADD1) || (state_q == S_ADD2)) && add_done;

  // ADD1 forms Re z^2 = re2 - im2 and |z|^2 = re2 + im2; ADD2 adds c.
  always_comb begin
    add_re_a = '0;
    add_re_b = '0;
    add_im_a = '0;
    add_im_b = '0;
    if (state_q == S_ADD1) begin
      add_re_a = re2_q;
      add_re_b = {~im2_q[63], im2_q[62:0]};
      add_im_a = re2_q;
      add_im_b = im2_q;
    end else if (state_q == S_ADD2) begin
      add_re_a = t_re_q;
      add_re_b = c_re_q;
      add_im_a = dbl(reim_q);
      add_im_b = c_im_q;
    end
  end

endmodule

// File: tb/tb_mandel_iter_ctrl.sv
// Directed bench for mandel_iter_ctrl with behavioural double-precision squaring and adder units.
module tb_mandel_iter_ctrl;

  localparam int ITER_W  = 16;
  localparam int SQ_LAT  = 3;
  localparam int ADD_LAT = 2;

  localparam logic [63:0] D_ZERO = 64'h0000_0000_0000_0000;
  localparam logic [63:0] D_ONE  = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] D_MONE = 64'hBFF0_0000_0000_0000;
  localparam logic [63:0] D_TWO  = 64'h4000_0000_0000_0000;
  localparam logic [63:0] D_MTWO = 64'hC000_0000_0000_0000;
  localparam logic [63:0] D_SIX  = 64'h4018_0000_0000_0000;

  logic              clk, reset, start, ack;
  logic [63:0]       c_re, c_im;
  logic [ITER_W-1:0] max_iter;
  logic              busy, done, escaped;
  logic [ITER_W-1:0] iter_count;
  logic [63:0]       z_re, z_im;
  logic              sq_start, sq_ack, sq_done;
  logic [63:0]       sq_re, sq_im, sq_re2, sq_im2, sq_reim;
  logic              add_start, add_ack, add_done;
  logic [63:0]       add_re_a, add_re_b, add_im_a, add_im_b, add_re_z, add_im_z;

  int checks   = 0;
  int failures = 0;
  int sq_hs    = 0;
  int add_hs   = 0;

  mandel_iter_ctrl #(.ITER_W(ITER_W)) dut (
    .clk(clk), .reset(reset), .start(start), .c_re(c_re), .c_im(c_im),
    .max_iter(max_iter), .busy(busy), .done(done), .ack(ack), .escaped(escaped),
    .iter_count(iter_count), .z_re(z_re), .z_im(z_im),
    .sq_start(sq_start), .sq_ack(sq_ack), .sq_re(sq_re), .sq_im(sq_im),
    .sq_done(sq_done), .sq_re2(sq_re2), .sq_im2(sq_im2), .sq_reim(sq_reim),
    .add_start(add_start), .add_ack(add_ack), .add_re_a(add_re_a), .add_re_b(add_re_b),
    .add_im_a(add_im_a), .add_im_b(add_im_b), .add_done(add_done),
    .add_re_z(add_re_z), .add_im_z(add_im_z)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Squaring unit model: latches operands on request, answers SQ_LAT cycles later for one cycle.
  initial begin
    logic [63:0] op_re, op_im;
    int cnt;
    bit pend;
    real ra, ia;
    sq_done = 1'b0; sq_re2 = '0; sq_im2 = '0; sq_reim = '0;
    pend = 0; cnt = 0; op_re = '0; op_im = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        sq_done = 1'b0; pend = 0;
      end else if (sq_done) begin
        sq_done = 1'b0;
      end else if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pend = 0;
          ra = $bitstoreal(op_re);
          ia = $bitstoreal(op_im);
          sq_re2  = $realtobits(ra * ra);
          sq_im2  = $realtobits(ia * ia);
          sq_reim = $realtobits(ra * ia);
          sq_done = 1'b1;
          #1;
          if (sq_ack) sq_hs++;
        end
      end else if (sq_start) begin
        op_re = sq_re; op_im = sq_im; pend = 1; cnt = SQ_LAT;
      end
    end
  end

  // Adder unit model.
  initial begin
    logic [63:0] ra_b, rb_b, ia_b, ib_b;
    int cnt;
    bit pend;
    add_done = 1'b0; add_re_z = '0; add_im_z = '0;
    pend = 0; cnt = 0; ra_b = '0; rb_b = '0; ia_b = '0; ib_b = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        add_done = 1'b0; pend = 0;
      end else if (add_done) begin
        add_done = 1'b0;
      end else if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pend = 0;
          add_re_z = $realtobits($bitstoreal(ra_b) + $bitstoreal(rb_b));
          add_im_z = $realtobits($bitstoreal(ia_b) + $bitstoreal(ib_b));
          add_done = 1'b1;
          #1;
          if (add_ack) add_hs++;
        end
      end else if (add_start) begin
        ra_b = add_re_a; rb_b = add_re_b; ia_b = add_im_a; ib_b = add_im_b;
        pend = 1; cnt = ADD_LAT;
      end
    end
  end

  // Driver: launch one point and wait (bounded) for done. Returns cycles waited.
  task automatic run_point(input logic [63:0] cr, input logic [63:0] ci,
                           input logic [ITER_W-1:0] mx, output bit timed_out, output int waited);
    @(negedge clk);
    c_re = cr; c_im = ci; max_iter = mx; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    timed_out = 1'b1;
    waited = 0;
    for (int i = 0; i < 4000; i++) begin
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, escaped, sq_start, sq_ack, add_start, add_ack} !== 7'd0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {busy, done, escaped, sq_start, sq_ack, add_start, add_ack});
    end
    checks++;
    if ({iter_count, z_re, z_im, add_re_a, add_re_b, add_im_a, add_im_b} !== '0) begin
      failures++;
      $display("FAIL reset_data: iter=%0d z_re=%h z_im=%h not all zero", iter_count, z_re, z_im);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero_c();
    bit to; int w;
    sq_hs = 0; add_hs = 0;
    run_point(D_ZERO, D_ZERO, 16'd10, to, w);
    checks++;
    if (to) begin failures++; $display("FAIL zero_c_timeout: done not seen after %0d cycles", w); end
    checks++;
    if ({escaped, iter_count} !== {1'b0, 16'd10}) begin
      failures++; $display("FAIL zero_c_result: esc=%0b iter=%0d want esc=0 iter=10", escaped, iter_count);
    end
    checks++;
    if ({z_re, z_im} !== {D_ZERO, D_ZERO}) begin
      failures++; $display("FAIL zero_c_z: got %h %h want 0 0", z_re, z_im);
    end
    checks++;
    if (sq_hs !== 10) begin failures++; $display("FAIL zero_c_sq_hs: got %0d want 10", sq_hs); end
    checks++;
    if (add_hs !== 20) begin failures++; $display("FAIL zero_c_add_hs: got %0d want 20 (ADD1+ADD2)", add_hs); end
    do_ack();
    checks++;
    if ({done, busy} !== 2'b00) begin failures++; $display("FAIL zero_c_ack: done/busy=%b want 00", {done, busy}); end
  endtask

  task automatic test_escape(input string tag);
    bit to; int w;
    run_point(D_TWO, D_ZERO, 16'd10, to, w);
    checks++;
    if (to) begin failures++; $display("FAIL %s_timeout: done not seen", tag); end
    checks++;
    if ({escaped, iter_count} !== {1'b1, 16'd2}) begin
      failures++; $display("FAIL %s_result: esc=%0b iter=%0d want esc=1 iter=2", tag, escaped, iter_count);
    end
    checks++;
    if ({z_re, z_im} !== {D_SIX, D_ZERO}) begin
      failures++; $display("FAIL %s_z: got %h %h want %h 0", tag, z_re, z_im, D_SIX);
    end
    do_ack();
  endtask

  task automatic test_boundary();
    bit to; int w;
    run_point(D_MTWO, D_ZERO, 16'd5, to, w);
    checks++;
    if (to) begin failures++; $display("FAIL boundary_timeout: done not seen"); end
    checks++;
    if ({escaped, iter_count} !== {1'b0, 16'd5}) begin
      failures++; $display("FAIL boundary_result: esc=%0b iter=%0d want esc=0 iter=5", escaped, iter_count);
    end
    checks++;
    if ({z_re, z_im} !== {D_TWO, D_ZERO}) begin
      failures++; $display("FAIL boundary_z: got %h %h want %h 0", z_re, z_im, D_TWO);
    end
    do_ack();
  endtask

  task automatic test_cycle();
    bit to; int w;
    run_point(D_ZERO, D_ONE, 16'd6, to, w);
    checks++;
    if (to) begin failures++; $display("FAIL cycle_timeout: done not seen"); end
    checks++;
    if ({escaped, iter_count} !== {1'b0, 16'd6}) begin
      failures++; $display("FAIL cycle_result: esc=%0b iter=%0d want esc=0 iter=6", escaped, iter_count);
    end
    checks++;
    if ({z_re, z_im} !== {D_MONE, D_ONE}) begin
      failures++; $display("FAIL cycle_z: got %h %h want %h %h", z_re, z_im, D_MONE, D_ONE);
    end
    do_ack();
  endtask

  task automatic test_max_zero();
    bit to; int w;
    sq_hs = 0; add_hs = 0;
    run_point(D_TWO, D_ONE, 16'd0, to, w);
    checks++;
    if (to || w > 1) begin failures++; $display("FAIL maxzero_latency: waited %0d timeout=%0b want <=1", w, to); end
    checks++;
    if ({escaped, iter_count, z_re, z_im} !== '0) begin
      failures++; $display("FAIL maxzero_result: esc=%0b iter=%0d z=%h %h want all 0", escaped, iter_count, z_re, z_im);
    end
    for (int i = 0; i < 20; i++) begin
      start = (i % 3 == 0);
      max_iter = 16'd5;
      @(negedge clk);
      checks++;
      if ({done, busy, escaped, iter_count, z_re, z_im} !== {1'b1, 1'b1, 1'b0, 16'd0, D_ZERO, D_ZERO}) begin
        failures++; $display("FAIL maxzero_hold[%0d]: done=%0b busy=%0b iter=%0d z=%h %h", i, done, busy, iter_count, z_re, z_im);
      end
    end
    start = 1'b0;
    checks++;
    if (sq_hs + add_hs !== 0) begin failures++; $display("FAIL maxzero_hs: got %0d handshakes want 0", sq_hs + add_hs); end
    do_ack();
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL maxzero_ack: done=%0b want 0", done); end
  endtask

  task automatic test_reset_mid();
    bit hit;
    add_hs = 0;
    @(negedge clk);
    c_re = D_TWO; c_im = D_ZERO; max_iter = 16'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 0;
    for (int i = 0; i < 500; i++) begin
      if (add_hs == 1 && add_start) begin hit = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL resetmid_reach: ADD2 request not seen"); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, escaped, sq_start, sq_ack, add_start, add_ack} !== 7'd0) begin
      failures++; $display("FAIL resetmid_ctrl: got %b want 0000000",
                           {busy, done, escaped, sq_start, sq_ack, add_start, add_ack});
    end
    checks++;
    if ({iter_count, z_re, z_im} !== '0) begin
      failures++; $display("FAIL resetmid_data: iter=%0d z=%h %h want 0", iter_count, z_re, z_im);
    end
    reset = 1'b0;
    test_escape("restart");
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ack = 1'b0;
    c_re = '0; c_im = '0; max_iter = '0;
    test_reset();
    test_zero_c();
    test_escape("escape");
    test_boundary();
    test_cycle();
    test_max_zero();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
